// File: rtl/s3_writeback_pkg.sv
// Shared definitions for the stage-3 writeback block: opcode fields,
// CSR addresses, load and CSR funct3 codes, and writeback-select encodings.
package s3_writeback_pkg;

    // Opcode[6:2] values of the instruction classes seen in stage 3
    localparam logic [4:0] OPC5_LOAD   = 5'b00000;
    localparam logic [4:0] OPC5_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC5_OP     = 5'b01100;
    localparam logic [4:0] OPC5_JAL    = 5'b11011;
    localparam logic [4:0] OPC5_JALR   = 5'b11001;
    localparam logic [4:0] OPC5_SYSTEM = 5'b11100;

    // CSR addresses
    localparam logic [11:0] CSR_TOHOST  = 12'h51E;
    localparam logic [11:0] CSR_CYCLE   = 12'hC00;
    localparam logic [11:0] CSR_INSTRET = 12'hC02;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // CSR funct3 codes
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // Writeback source select; the reserved code behaves like ALU
    typedef enum logic [1:0] {
        WB_LOAD = 2'd0,
        WB_ALU  = 2'd1,
        WB_PC4  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    // Only the plain and immediate "write" CSR forms modify a CSR
    function automatic logic csr_f3_writes(input logic [2:0] f3);
        return (f3 == F3_CSRRW) || (f3 == F3_CSRRWI);
    endfunction

endpackage

// File: rtl/s3_writeback_load_extract.sv
// Combinational load-data extraction: selects the byte or halfword
// addressed by the low address bits and sign- or zero-extends it.
module load_extract
    import s3_writeback_pkg::*;
(
    input  logic [31:0] dmem_rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword, then extend according to funct3
    always_comb begin
        byte_sel = dmem_rdata[7:0];
        case (off)
            2'd0: byte_sel = dmem_rdata[7:0];
            2'd1: byte_sel = dmem_rdata[15:8];
            2'd2: byte_sel = dmem_rdata[23:16];
            2'd3: byte_sel = dmem_rdata[31:24];
            default: byte_sel = dmem_rdata[7:0];
        endcase
        half_sel = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        result = dmem_rdata;
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = dmem_rdata;
        endcase
    end

endmodule

// File: rtl/s3_writeback.sv
// Stage-3 writeback/retire block: register-file write port, CSR state
// (tohost and optional cycle/instret counters) and a one-entry registered
// forwarding copy of the last retired write.
// Define S3_COUNTERS_EN to build the cycle/instret counters; without it the
// counter CSRs read as zero.
module s3_writeback
    import s3_writeback_pkg::*;
#(
    parameter logic [11:0] CSR_TOHOST_ADDR  = CSR_TOHOST,
    parameter logic [11:0] CSR_CYCLE_ADDR   = CSR_CYCLE,
    parameter logic [11:0] CSR_INSTRET_ADDR = CSR_INSTRET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_s3,
    input  logic        stall,
    input  logic [31:0] instruction_s3,
    input  logic [31:0] pc_s3,
    input  logic [31:0] alu_s3,
    input  logic [31:0] rs1_data_s3,
    input  logic [31:0] dmem_rdata,
    input  logic [1:0]  wb_sel,
    input  logic        reg_we,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        fwd_valid,
    output logic [4:0]  fwd_addr,
    output logic [31:0] fwd_data,
    output logic [31:0] tohost,
    output logic        retire
);

    logic [4:0]  opcode5;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  zimm;
    logic [11:0] csr_addr;
    logic        is_csr;
    logic        tohost_wr;
    logic [31:0] load_data;
    logic [31:0] csr_rdata;
    logic [31:0] cycle_rd;
    logic [31:0] instret_rd;
    logic        unused_opcode_lsbs;

    logic [31:0] tohost_q, tohost_d;
    logic        fwd_valid_q, fwd_valid_d;
    logic [4:0]  fwd_addr_q, fwd_addr_d;
    logic [31:0] fwd_data_q, fwd_data_d;

    assign opcode5            = instruction_s3[6:2];
    assign funct3             = instruction_s3[14:12];
    assign rd                 = instruction_s3[11:7];
    assign zimm               = instruction_s3[19:15];
    assign csr_addr           = instruction_s3[31:20];
    assign unused_opcode_lsbs = ^instruction_s3[1:0];

    load_extract u_load_extract (
        .dmem_rdata (dmem_rdata),
        .off        (alu_s3[1:0]),
        .funct3     (funct3),
        .result     (load_data)
    );

    // Retire qualification and register-file write port; reset masks both
    always_comb begin
        retire   = valid_s3 & ~stall & ~rst;
        rf_waddr = rd;
        rf_we    = retire & reg_we & (rd != 5'd0);
        is_csr   = (opcode5 == OPC5_SYSTEM) && (funct3 != 3'd0);
    end

    // CSR read mux; counters return their value before this edge's increment
    always_comb begin
        csr_rdata = 32'd0;
        if (csr_addr == CSR_TOHOST_ADDR) begin
            csr_rdata = tohost_q;
        end else if (csr_addr == CSR_CYCLE_ADDR) begin
            csr_rdata = cycle_rd;
        end else if (csr_addr == CSR_INSTRET_ADDR) begin
            csr_rdata = instret_rd;
        end
    end

    // Writeback data select; load and link sources win over a CSR decode
    always_comb begin
        rf_wdata = alu_s3;
        if (wb_sel == WB_LOAD) begin
            rf_wdata = load_data;
        end else if (wb_sel == WB_PC4) begin
            rf_wdata = pc_s3 + 32'd4;
        end else if (is_csr) begin
            rf_wdata = csr_rdata;
        end
    end

    // Next-state for tohost and the forwarding entry; both hold unless retiring
    always_comb begin
        tohost_wr   = retire & is_csr & csr_f3_writes(funct3) &
                      (csr_addr == CSR_TOHOST_ADDR);
        tohost_d    = tohost_q;
        fwd_valid_d = fwd_valid_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_data_d  = fwd_data_q;
        if (tohost_wr) begin
            tohost_d = (funct3 == F3_CSRRWI) ? {27'd0, zimm} : rs1_data_s3;
        end
        if (retire) begin
            fwd_valid_d = rf_we;
            fwd_addr_d  = rf_waddr;
            fwd_data_d  = rf_wdata;
        end
    end

    // tohost and forwarding registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_q    <= 32'd0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= 5'd0;
            fwd_data_q  <= 32'd0;
        end else begin
            tohost_q    <= tohost_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

`ifdef S3_COUNTERS_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;

    // Free-running cycle count and retire count, both wrapping silently
    always_comb begin
        cycle_d   = cycle_q + 32'd1;
        instret_d = instret_q + {31'd0, retire};
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_rd   = cycle_q;
    assign instret_rd = instret_q;
`else
    assign cycle_rd   = 32'd0;
    assign instret_rd = 32'd0;
`endif

    assign tohost    = tohost_q;
    assign fwd_valid = fwd_valid_q;
    assign fwd_addr  = fwd_addr_q;
    assign fwd_data  = fwd_data_q;

endmodule

// File: tb/tb_s3_writeback.sv
// Self-checking bench for s3_writeback: a vector table of single-cycle
// instructions with a forwarding scoreboard, plus hand-written sequences for
// counters (S3_COUNTERS_EN aware) and reset during a retiring CSR write.
module tb_s3_writeback;

    logic        clk;
    logic        rst;
    logic        valid_s3;
    logic        stall;
    logic [31:0] instruction_s3;
    logic [31:0] pc_s3;
    logic [31:0] alu_s3;
    logic [31:0] rs1_data_s3;
    logic [31:0] dmem_rdata;
    logic [1:0]  wb_sel;
    logic        reg_we;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic [31:0] tohost;
    logic        retire;

    int passCount = 0;
    int totalCount = 0;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_OP   = 7'b0110011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    typedef struct {
        logic        valid;
        logic        stall;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rs1;
        logic [31:0] dmem;
        logic [1:0]  wbSel;
        logic        regWe;
        logic        expRetire;
        logic        expWe;
        logic [4:0]  expWaddr;
        logic [31:0] expWdata;
        logic [31:0] expTohost;
    } vec_t;

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
    } fwd_t;

    vec_t vecs [18];
    fwd_t sb [$];
    fwd_t curFwd;

    s3_writeback dut (
        .clk            (clk),
        .rst            (rst),
        .valid_s3       (valid_s3),
        .stall          (stall),
        .instruction_s3 (instruction_s3),
        .pc_s3          (pc_s3),
        .alu_s3         (alu_s3),
        .rs1_data_s3    (rs1_data_s3),
        .dmem_rdata     (dmem_rdata),
        .wb_sel         (wb_sel),
        .reg_we         (reg_we),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .fwd_valid      (fwd_valid),
        .fwd_addr       (fwd_addr),
        .fwd_data       (fwd_data),
        .tohost         (tohost),
        .retire         (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] enc(input logic [11:0] imm, input logic [4:0] rs1f,
                                        input logic [2:0] f3, input logic [4:0] rdf,
                                        input logic [6:0] opc);
        return {imm, rs1f, f3, rdf, opc};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        valid_s3       = v.valid;
        stall          = v.stall;
        instruction_s3 = v.instr;
        pc_s3          = v.pc;
        alu_s3         = v.alu;
        rs1_data_s3    = v.rs1;
        dmem_rdata     = v.dmem;
        wb_sel         = v.wbSel;
        reg_we         = v.regWe;
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] instr,
                         input logic [31:0] rs1, input logic [1:0] ws);
        valid_s3       = v;
        stall          = s;
        instruction_s3 = instr;
        rs1_data_s3    = rs1;
        wb_sel         = ws;
        reg_we         = 1'b1;
        pc_s3          = 32'h0000_0100;
        alu_s3         = 32'h0000_0BAD;
        dmem_rdata     = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkFwd(input string tag);
        checkOutput({tag, " fwd_valid"}, {31'd0, fwd_valid}, {31'd0, curFwd.v});
        checkOutput({tag, " fwd_addr"}, {27'd0, fwd_addr}, {27'd0, curFwd.a});
        checkOutput({tag, " fwd_data"}, fwd_data, curFwd.d);
    endtask

    initial begin
        logic [31:0] expCycleRd;
        logic [31:0] expInstretRd;
        string tag;

        // Vector table: one instruction per cycle, tohost is the value seen in that cycle
        vecs[0]  = '{1'b1, 1'b0, enc(12'h0, 5'd1, 3'b000, 5'd5, OP_LOAD), 32'h0, 32'h0000_1003,
                     32'h0, 32'h80FF_1234, 2'd0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hFFFF_FF80, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, enc(12'h0, 5'd1, 3'b100, 5'd6, OP_LOAD), 32'h0, 32'h0000_1003,
                     32'h0, 32'h80FF_1234, 2'd0, 1'b1, 1'b1, 1'b1, 5'd6, 32'h0000_0080, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, enc(12'h0, 5'd1, 3'b001, 5'd7, OP_LOAD), 32'h0, 32'h0000_1003,
                     32'h0, 32'h80FF_1234, 2'd0, 1'b1, 1'b1, 1'b1, 5'd7, 32'hFFFF_80FF, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, enc(12'h0, 5'd1, 3'b101, 5'd8, OP_LOAD), 32'h0, 32'h0000_1001,
                     32'h0, 32'h80FF_1234, 2'd0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h0000_1234, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, enc(12'h0, 5'd1, 3'b010, 5'd9, OP_LOAD), 32'h0, 32'h0000_1002,
                     32'h0, 32'h80FF_1234, 2'd0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h80FF_1234, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, enc(12'h010, 5'd0, 3'b000, 5'd1, OP_JAL), 32'h0000_2000, 32'h0000_2010,
                     32'h0, 32'h0, 2'd2, 1'b1, 1'b1, 1'b1, 5'd1, 32'h0000_2004, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, enc(12'h0, 5'd2, 3'b000, 5'd0, OP_OP), 32'h0, 32'h0000_DEAD,
                     32'h0, 32'h0, 2'd1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_DEAD, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, enc(12'h0, 5'd2, 3'b000, 5'd4, OP_OP), 32'h0, 32'h0000_1111,
                     32'h0, 32'h0, 2'd1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h0000_1111, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, enc(12'h0, 5'd2, 3'b000, 5'd4, OP_OP), 32'h0, 32'h0000_1111,
                     32'h0, 32'h0, 2'd3, 1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_1111, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, enc(12'h51E, 5'd5, 3'b101, 5'd3, OP_SYS), 32'h0, 32'h0000_9999,
                     32'h0, 32'h0, 2'd1, 1'b1, 1'b1, 1'b1, 5'd3, 32'h0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, enc(12'h51E, 5'd0, 3'b010, 5'd10, OP_SYS), 32'h0, 32'h0,
                     32'h0, 32'h0, 2'd1, 1'b1, 1'b1, 1'b1, 5'd10, 32'h5, 32'h5};
        vecs[11] = '{1'b1, 1'b0, enc(12'h51E, 5'd7, 3'b001, 5'd11, OP_SYS), 32'h0, 32'h0,
                     32'hCAFE_0001, 32'h0, 2'd1, 1'b1, 1'b1, 1'b1, 5'd11, 32'h5, 32'h5};
        vecs[12] = '{1'b1, 1'b0, enc(12'h51E, 5'd7, 3'b011, 5'd12, OP_SYS), 32'h0, 32'h0,
                     32'hFFFF_FFFF, 32'h0, 2'd1, 1'b1, 1'b1, 1'b1, 5'd12, 32'hCAFE_0001, 32'hCAFE_0001};
        vecs[13] = '{1'b0, 1'b0, enc(12'h51E, 5'd7, 3'b001, 5'd13, OP_SYS), 32'h0, 32'h0,
                     32'h0000_0077, 32'h0, 2'd1, 1'b1, 1'b0, 1'b0, 5'd13, 32'hCAFE_0001, 32'hCAFE_0001};
        vecs[14] = '{1'b1, 1'b0, enc(12'h123, 5'd0, 3'b010, 5'd13, OP_SYS), 32'h0, 32'h0,
                     32'h0, 32'h0, 2'd1, 1'b1, 1'b1, 1'b1, 5'd13, 32'h0, 32'hCAFE_0001};
        vecs[15] = '{1'b1, 1'b1, enc(12'h51E, 5'd7, 3'b001, 5'd14, OP_SYS), 32'h0, 32'h0,
                     32'h0000_0001, 32'h0, 2'd1, 1'b1, 1'b0, 1'b0, 5'd14, 32'hCAFE_0001, 32'hCAFE_0001};
        vecs[16] = '{1'b1, 1'b0, enc(12'h0, 5'd2, 3'b000, 5'd2, OP_OP), 32'h0, 32'h0000_0042,
                     32'h0, 32'h0, 2'd1, 1'b1, 1'b1, 1'b1, 5'd2, 32'h0000_0042, 32'hCAFE_0001};
        vecs[17] = '{1'b1, 1'b0, enc(12'h0, 5'd0, 3'b000, 5'd15, OP_SYS), 32'h0, 32'h0000_0055,
                     32'h0, 32'h0, 2'd1, 1'b1, 1'b1, 1'b1, 5'd15, 32'h0000_0055, 32'hCAFE_0001};

        // Reset with a valid instruction presented: retire and rf_we must be masked
        rst = 1'b1;
        drive(1'b1, 1'b0, enc(12'h0, 5'd2, 3'b000, 5'd4, OP_OP), 32'h0, 2'd1);
        #1;
        checkOutput("reset retire", {31'd0, retire}, 32'd0);
        checkOutput("reset rf_we", {31'd0, rf_we}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        valid_s3 = 1'b0;
        curFwd = '{1'b0, 5'd0, 32'd0};
        checkFwd("reset");
        checkOutput("reset tohost", tohost, 32'd0);

        // Table-driven single-cycle vectors with forwarding scoreboard
        for (int i = 0; i < 18; i++) begin
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i]);
            #1;
            checkOutput({tag, " retire"}, {31'd0, retire}, {31'd0, vecs[i].expRetire});
            checkOutput({tag, " rf_we"}, {31'd0, rf_we}, {31'd0, vecs[i].expWe});
            checkOutput({tag, " rf_waddr"}, {27'd0, rf_waddr}, {27'd0, vecs[i].expWaddr});
            checkOutput({tag, " rf_wdata"}, rf_wdata, vecs[i].expWdata);
            checkOutput({tag, " tohost"}, tohost, vecs[i].expTohost);
            if (vecs[i].expRetire) begin
                sb.push_back('{vecs[i].expWe, vecs[i].expWaddr, vecs[i].expWdata});
            end
            tick();
            if (sb.size() > 0) begin
                curFwd = sb.pop_front();
            end
            checkFwd(tag);
        end

        // Counters: reset, then 10 edges with 4 retires and some stalled cycles
        valid_s3 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, (i >= 4 && i < 7), enc(12'h0, 5'd2, 3'b000, 5'd6, OP_OP), 32'h0, 2'd1);
            if (i >= 7) valid_s3 = 1'b0;
            tick();
        end
`ifdef S3_COUNTERS_EN
        expInstretRd = 32'd4;
        expCycleRd   = 32'd10;
`else
        expInstretRd = 32'd0;
        expCycleRd   = 32'd0;
`endif
        drive(1'b0, 1'b0, enc(12'hC02, 5'd0, 3'b010, 5'd1, OP_SYS), 32'h0, 2'd1);
        #1;
        checkOutput("instret read", rf_wdata, expInstretRd);
        drive(1'b0, 1'b0, enc(12'hC00, 5'd0, 3'b010, 5'd1, OP_SYS), 32'h0, 2'd1);
        #1;
        checkOutput("cycle read", rf_wdata, expCycleRd);
        drive(1'b1, 1'b0, enc(12'hC00, 5'd9, 3'b001, 5'd1, OP_SYS), 32'h0000_1234, 2'd1);
        #1;
        checkOutput("csrrw cycle old value", rf_wdata, expCycleRd);
        tick();
        drive(1'b0, 1'b0, enc(12'hC00, 5'd0, 3'b010, 5'd1, OP_SYS), 32'h0, 2'd1);
        #1;
        checkOutput("cycle after write attempt", rf_wdata, (expCycleRd == 32'd0) ? 32'd0 : 32'd11);
        drive(1'b0, 1'b0, enc(12'hC02, 5'd0, 3'b010, 5'd1, OP_SYS), 32'h0, 2'd1);
        #1;
        checkOutput("instret after write attempt", rf_wdata, (expInstretRd == 32'd0) ? 32'd0 : 32'd5);
        checkOutput("tohost after counter write", tohost, 32'd0);

        // Reset dominating a retiring csrrw to tohost
        drive(1'b1, 1'b0, enc(12'h51E, 5'd7, 3'b101, 5'd3, OP_SYS), 32'h0, 2'd1);
        tick();
        checkOutput("pre-reset tohost", tohost, 32'd7);
        checkOutput("pre-reset fwd_valid", {31'd0, fwd_valid}, 32'd1);
        drive(1'b1, 1'b0, enc(12'h51E, 5'd8, 3'b001, 5'd5, OP_SYS), 32'h0000_00AA, 2'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst retire", {31'd0, retire}, 32'd0);
        checkOutput("rst rf_we", {31'd0, rf_we}, 32'd0);
        tick();
        rst = 1'b0;
        valid_s3 = 1'b0;
        #1;
        checkOutput("rst tohost", tohost, 32'd0);
        curFwd = '{1'b0, 5'd0, 32'd0};
        checkFwd("rst");

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/s3_writeback.md
# s3_writeback

Stage-3 writeback/retire block of the 3-stage RV32I core. It consumes the stage-3 instruction, the control decode produced alongside it (`wb_sel`, `reg_we`), the ALU result and the data-memory read word, and performs three jobs:
- drives the register-file write port;
- owns the CSR state (`tohost`, cycle/instret counters);
- holds a one-entry registered forwarding copy of the last retired write for the stage-2 bypass.

## Interface
Parameters:
- `CSR_TOHOST_ADDR`, 12'h51E: CSR address of the `tohost` register.
- `CSR_CYCLE_ADDR`, 12'hC00: read-only cycle counter address.
- `CSR_INSTRET_ADDR`, 12'hC02: read-only retired-instruction counter address.

Ports:
- `clk` in 1: core clock, single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `valid_s3` in 1: stage 3 holds a real instruction (0 = bubble).
- `stall` in 1: stage 3 frozen this cycle; no state update, no retire.
- `instruction_s3` in 32: stage-3 instruction word.
- `pc_s3` in 32: PC of the stage-3 instruction.
- `alu_s3` in 32: ALU result; this is the memory address for loads.
- `rs1_data_s3` in 32: rs1 value, used as the CSR write source.
- `dmem_rdata` in 32: aligned data-memory read word.
- `wb_sel` in 2: 0 = load, 1 = ALU, 2 = PC+4, 3 = reserved (treated as ALU).
- `reg_we` in 1: register write enable from stage-3 decode.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out 5: destination register (`instruction_s3[11:7]`).
- `rf_wdata` out 32: writeback data.
- `fwd_valid` out 1, `fwd_addr` out 5, `fwd_data` out 32: registered copy of the last retired write.
- `tohost` out 32: `tohost` CSR contents.
- `retire` out 1: an instruction retires this cycle.

## Operation
- Retire condition: `valid_s3 & ~stall`. `retire` equals this condition, combinationally.
- `rf_we` = `retire & reg_we & (rd != 0)`. A write to x0 is never asserted.
- Load extract, with `off = alu_s3[1:0]`:
  - LB/LBU: byte `off`, sign- or zero-extended.
  - LH/LHU: halfword selected by `alu_s3[1]` (`alu_s3[0]` ignored), sign- or zero-extended.
  - LW: the full word; offset ignored.
  - Any other funct3: the full word.
- `rf_wdata` select:
  - load extract when `wb_sel` = 0;
  - `pc_s3 + 4` when `wb_sel` = 2;
  - CSR read data when opcode[6:2] = 5'b11100 and funct3 != 0;
  - `alu_s3` otherwise.
- CSR read data:
  - `tohost` at `CSR_TOHOST_ADDR`;
  - cycle[31:0] at `CSR_CYCLE_ADDR`;
  - instret[31:0] at `CSR_INSTRET_ADDR`;
  - 0 for any other address.
- CSR writes (on retire only):
  - csrrw (funct3 001) writes `rs1_data_s3`.
  - csrrwi (101) writes zero-extended `instruction_s3[19:15]`.
  - Only `tohost` is writable. Writes to counters or unknown addresses are ignored.
  - csrrs, csrrc and their immediate forms never write.
- Read-then-write: csrrw on `tohost` returns the old value in `rf_wdata`. The new value is visible from the next cycle.

## Timing
- `rf_*` and `retire` are combinational from the stage-3 inputs. The register file captures them on the next `clk` edge.
- On each `clk` edge with `retire`:
  - `fwd_valid` <= `rf_we`, `fwd_addr` <= `rf_waddr`, `fwd_data` <= `rf_wdata`.
- On edges without `retire`, `fwd_*` hold. A stall never clears forwarding.
- `tohost` updates on the edge ending the retiring CSR write (latency 1).
- cycle increments every non-reset edge, regardless of stall. instret increments on each retire edge.
- Counter reads return the pre-increment value. Both counters are 32-bit and wrap from 0xFFFFFFFF to 0 silently.
- Reset (synchronous, any cycle, including mid-stall):
  - `tohost`, cycle, instret, `fwd_valid`, `fwd_addr`, `fwd_data` all <= 0.
  - `rf_we` and `retire` are forced to 0 combinationally while `rst` is high.
- `rst` dominates any simultaneous retire, CSR write or counter increment.

## Configuration
- `S3_COUNTERS_EN` defined: cycle and instret registers are built as described above.
- `S3_COUNTERS_EN` undefined: no counter flops. Reads of `CSR_CYCLE_ADDR`/`CSR_INSTRET_ADDR` return 0. `tohost` and forwarding are unchanged.

## Structure
- Shared header (with the existing opcode defines):
  - CSR address constants;
  - load funct3 codes (LB/LH/LW/LBU/LHU);
  - CSR funct3 codes;
  - `wb_sel` encodings (0 = load, 1 = ALU, 2 = PC+4);
  - the 5-bit CSR opcode 5'b11100.
- One sub-module, `load_extract`: purely combinational; inputs `dmem_rdata`, `off`, `funct3`; output the 32-bit result.

## Test plan
- LB at `alu_s3` = 0x1003, `dmem_rdata` = 0x80FF_1234 -> `rf_wdata` = 0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- JAL with `pc_s3` = 0x0000_2000, `wb_sel` = 2, rd = x1 -> `rf_we` = 1, `rf_wdata` = 0x2004. Next cycle: `fwd_valid` = 1, `fwd_addr` = 1, `fwd_data` = 0x2004.
- csrrwi 0x51E, zimm = 5, rd = x3, `tohost` = 0 -> `rf_wdata` = 0; `tohost` = 5 on the next cycle.
- ADD with rd = x0 and `reg_we` = 1 -> `rf_we` = 0. Same instruction with `stall` = 1 -> `retire` = 0 and `fwd_*` unchanged.
- `S3_COUNTERS_EN` build: reset, then 10 cycles with 4 retires -> csrrs rd, 0xC02, x0 reads 4 and 0xC00 reads 10. Attempted csrrw to 0xC00 -> counter unaffected.
- Assert `rst` while a csrrw to `tohost` is retiring -> `tohost` = 0, `fwd_valid` = 0, `rf_we` = 0 that cycle.
